// File: rtl/gf180mcu_fd_io__ring_seq.sv
// gf180mcu_fd_io__ring_seq: IO-ring bring-up sequencer gating pad IE/OE until the IO supply is stable, then releasing OE groups staggered
// Ports: clk, rstn (async active-low), pwrgd (async supply good), shdn (sync shutdown request),
//        oe_req/ie_req (core requests, pad p in group p/GROUP_W), oe/ie (registered pad enables),
//        ready (registered, all groups released).
// Optional: define GF180MCU_FD_IO_RAMP_DOWN_EN for a staggered reverse-order ramp-down on shdn.
module gf180mcu_fd_io__ring_seq #(
  parameter int NGROUPS = 4,
  parameter int GROUP_W = 8,
  parameter int SETTLE_CYC = 16,
  parameter int STAGGER_CYC = 8
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       pwrgd,
  input  logic                       shdn,
  input  logic [NGROUPS*GROUP_W-1:0] oe_req,
  input  logic [NGROUPS*GROUP_W-1:0] ie_req,
  output logic [NGROUPS*GROUP_W-1:0] oe,
  output logic [NGROUPS*GROUP_W-1:0] ie,
  output logic                       ready
);
  localparam int CMAX = SETTLE_CYC > STAGGER_CYC ? SETTLE_CYC : STAGGER_CYC;
  localparam int CW = $clog2(CMAX + 1);
  localparam int GW = $clog2(NGROUPS + 1);
  typedef enum logic [2:0] {OFF, SETTLE, IE_ON, RAMP, RUN, HOLD, DOWN} state_t;
  state_t st, st_n;
  logic s1, pg_s, ieg, ieg_n, stag;
  logic [CW-1:0] cnt, cnt_n;
  logic [GW-1:0] g, g_n;
  logic [NGROUPS-1:0] gen, gen_n;
  logic [NGROUPS*GROUP_W-1:0] mask;
  for (genvar i = 0; i < NGROUPS; i++) begin : g_mask
    assign mask[i*GROUP_W +: GROUP_W] = {GROUP_W{gen[i]}};
  end
  assign stag = cnt == CW'(STAGGER_CYC - 1);
  // The stagger counter runs continuously from IE_ON entry so group k
  // releases (k+1)*STAGGER_CYC edges after the IE gate opens.
  always_comb begin
    st_n = st;
    cnt_n = '0;
    g_n = g;
    gen_n = gen;
    ieg_n = ieg;
    case (st)
      OFF: st_n = pg_s && !shdn ? SETTLE : OFF;
      SETTLE: begin
        if (cnt == CW'(SETTLE_CYC - 1)) begin
          st_n = IE_ON;
          ieg_n = 1'b1;
        end else cnt_n = cnt + CW'(1);
      end
      IE_ON, RAMP: begin
        st_n = RAMP;
        if (stag) begin
          gen_n = gen | (NGROUPS'(1) << g);
          g_n = g + GW'(1);
          if (g == GW'(NGROUPS - 1)) st_n = RUN;
        end else cnt_n = cnt + CW'(1);
      end
      HOLD: st_n = shdn ? HOLD : OFF;
      DOWN: begin
        if (!stag) cnt_n = cnt + CW'(1);
        else if (g == '0) begin
          ieg_n = 1'b0;
          st_n = HOLD;
        end else begin
          gen_n = gen & ~(NGROUPS'(1) << (g - GW'(1)));
          g_n = g - GW'(1);
        end
      end
      default: ;
    endcase
`ifdef GF180MCU_FD_IO_RAMP_DOWN_EN
    if (shdn && (st == RAMP || st == RUN)) begin
      st_n = DOWN;
      cnt_n = '0;
      g_n = g;
      gen_n = gen;
      ieg_n = ieg;
    end
    if (shdn && (st == SETTLE || st == IE_ON)) begin
      st_n = HOLD;
      cnt_n = '0;
      g_n = '0;
      gen_n = '0;
      ieg_n = 1'b0;
    end
`else
    if (shdn && st inside {SETTLE, IE_ON, RAMP, RUN}) begin
      st_n = HOLD;
      cnt_n = '0;
      g_n = '0;
      gen_n = '0;
      ieg_n = 1'b0;
    end
`endif
    // Supply loss overrides shutdown handling and any ramp in progress.
    if (!pg_s && st != OFF) begin
      st_n = OFF;
      cnt_n = '0;
      g_n = '0;
      gen_n = '0;
      ieg_n = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1 <= 1'b0;
      pg_s <= 1'b0;
      st <= OFF;
      cnt <= '0;
      g <= '0;
      gen <= '0;
      ieg <= 1'b0;
      oe <= '0;
      ie <= '0;
      ready <= 1'b0;
    end else begin
      s1 <= pwrgd;
      pg_s <= s1;
      st <= st_n;
      cnt <= cnt_n;
      g <= g_n;
      gen <= gen_n;
      ieg <= ieg_n;
      oe <= oe_req & mask;
      ie <= ie_req & {NGROUPS*GROUP_W{ieg}};
      ready <= st == RUN;
    end
  end
endmodule
